// File: rtl/dual_debounce.sv
// dual_debounce: two-channel synchronise-and-debounce front end feeding the OR gate stage
module debounce_ch #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise
);
  typedef enum logic [1:0] {
    LO_STABLE = 2'b00,
    LO_ARM    = 2'b01,
    HI_STABLE = 2'b10,
    HI_ARM    = 2'b11
  } state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic s1, s2, hi, arm, trig, done, nxt_rise;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  state_t state, nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LO_STABLE;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= nxt_cnt;
      rise  <= nxt_rise;
    end
  // state[1] is the clean level and state[0] marks an armed count, so both halves share one rule
  always_comb begin
    hi       = state[1];
    arm      = state[0];
    trig     = s2 ^ hi;
    done     = trig & (arm ? cnt == LAST : STABLE_CYCLES == 1);
    nxt      = done ? state_t'({~hi, 1'b0}) : state_t'({hi, trig});
    nxt_cnt  = (trig & ~done) ? cnt + 1'b1 : '0;
    nxt_rise = done & ~hi;
  end
  always_comb clean = state[1];
endmodule

module dual_debounce #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_clean,
  output logic b_clean,
  output logic a_rise,
  output logic b_rise
);
  debounce_ch #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_a (
    .clk(clk), .rst_n(rst_n), .raw(a_raw), .clean(a_clean), .rise(a_rise)
  );
  debounce_ch #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_b (
    .clk(clk), .rst_n(rst_n), .raw(b_raw), .clean(b_clean), .rise(b_rise)
  );
endmodule

// File: tb/tb_dual_debounce.sv
// tb_dual_debounce: random and directed stimulus against a sample-window reference model
module tb_dual_debounce;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a_clean, b_clean, a_rise, b_rise;
  logic a_clean1, b_clean1, a_rise1, b_rise1;
  int checks = 0;
  int passes = 0;
  logic [7:0] expq[$];
  bit s1[2], s2[2];
  bit hist[2][$];
  bit cl[2][2], rs[2][2];
  always #5 clk = ~clk;
  dual_debounce #(.STABLE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a_raw(a_raw), .b_raw(b_raw),
    .a_clean(a_clean), .b_clean(b_clean), .a_rise(a_rise), .b_rise(b_rise)
  );
  dual_debounce #(.STABLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .a_raw(a_raw), .b_raw(b_raw),
    .a_clean(a_clean1), .b_clean(b_clean1), .a_rise(a_rise1), .b_rise(b_rise1)
  );
  // Reference: clean flips once the last N synchronised samples all disagree with it
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        s1[c] = 0;
        s2[c] = 0;
        hist[c].delete();
        for (int i = 0; i < 2; i++) begin
          cl[i][c] = 0;
          rs[i][c] = 0;
        end
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        hist[c].push_back(s2[c]);
        if (hist[c].size() > 8) void'(hist[c].pop_front());
        s2[c] = s1[c];
        s1[c] = (c == 0) ? a_raw : b_raw;
      end
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < 2; c++) begin
          int n;
          bit flip;
          n = (i == 0) ? 4 : 1;
          flip = hist[c].size() >= n;
          for (int k = 0; k < n; k++)
            if (flip && hist[c][hist[c].size() - 1 - k] == cl[i][c]) flip = 0;
          rs[i][c] = flip & !cl[i][c];
          if (flip) cl[i][c] = !cl[i][c];
        end
    end
    expq.push_back({cl[0][0], cl[0][1], rs[0][0], rs[0][1], cl[1][0], cl[1][1], rs[1][0], rs[1][1]});
  end
  initial forever begin
    logic [7:0] exp_v, act_v;
    @(posedge clk);
    #1;
    act_v = {a_clean, b_clean, a_rise, b_rise, a_clean1, b_clean1, a_rise1, b_rise1};
    checks++;
    if (expq.size() == 0) $display("FAIL scoreboard_empty t=%0t actual=%b required=<entry>", $time, act_v);
    else begin
      exp_v = expq.pop_front();
      if (act_v === exp_v) passes++;
      else $display("FAIL outputs t=%0t actual=%b required=%b (a_clean,b_clean,a_rise,b_rise x N=4,N=1)", $time, act_v, exp_v);
    end
  end
  task automatic step(input logic a, input logic b, input logic r, input int cycles);
    @(negedge clk);
    a_raw = a;
    b_raw = b;
    rst_n = r;
    repeat (cycles - 1) @(negedge clk);
  endtask
  initial begin
    int ha, hb;
    logic va, vb;
    step(1, 1, 0, 3);
    step(1, 1, 1, 10);
    step(0, 0, 1, 10);
    step(1, 0, 1, 8);
    step(0, 0, 1, 8);
    step(1, 0, 1, 1);
    step(0, 0, 1, 1);
    step(1, 0, 1, 1);
    step(0, 0, 1, 1);
    step(1, 0, 1, 10);
    step(0, 0, 1, 10);
    step(0, 1, 1, 3);
    step(0, 0, 1, 8);
    step(1, 1, 1, 8);
    step(0, 0, 1, 8);
    step(0, 1, 1, 4);
    step(0, 1, 0, 2);
    step(0, 1, 1, 10);
    step(0, 0, 1, 8);
    ha = 0;
    hb = 0;
    va = 0;
    vb = 0;
    for (int t = 0; t < 1200; t++) begin
      if (ha == 0) begin
        va = 1'($urandom_range(0, 1));
        ha = $urandom_range(1, 9);
      end
      if (hb == 0) begin
        vb = 1'($urandom_range(0, 1));
        hb = $urandom_range(1, 9);
      end
      ha--;
      hb--;
      step(va, vb, ($urandom_range(0, 149) != 0), 1);
    end
    step(0, 0, 1, 4);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
